// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and receive FIFO address width.
// The receiver and the receive FIFO take their parameter defaults from here.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_RX_FIFO_ADDR_W = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array.
// It has one synchronous write port and one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_RX_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents are deliberately not reset; the FIFO flags say what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular byte buffer with first-word fall-through read.
// Optional sticky overflow flag and ovf_clr port: define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_RX_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
`ifdef UART_RX_FIFO_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              overflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              do_wr, do_rd;

  // A write while full only lands when a pop frees the head in the same cycle.
  always_comb begin
    do_wr   = wr && (!full_q || rd);
    do_rd   = rd && !empty_q;
    w_ptr_d = w_ptr_q + {{(ADDR_W-1){1'b0}}, do_wr};
    r_ptr_d = r_ptr_q + {{(ADDR_W-1){1'b0}}, do_rd};
    level_d = level_q + {{ADDR_W{1'b0}}, do_wr} - {{ADDR_W{1'b0}}, do_rd};
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

`ifdef UART_RX_FIFO_OVF_EN
  logic overflow_q, overflow_d;

  // Setting wins over a clear in the same cycle so no drop goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (wr && full_q && !rd) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

  uart_fifo_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (do_wr),
    .waddr(w_ptr_q),
    .wdata(w_data),
    .raddr(r_ptr_q),
    .rdata(r_data)
  );

  assign empty = empty_q;
  assign full  = full_q;
  assign level = level_q;

endmodule
